// File: rtl/cfg_chain_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader and its word serdes.
package cfg_chain_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_READ = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  localparam logic MODE_LOAD = 1'b0;
  localparam logic MODE_READ = 1'b1;

  function automatic int words_per_chain(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/cfg_word_serdes.sv
// Word-wide shift register with bit index: serialises LSB first in load mode,
// deserialises LSB first with zero padding in readback mode.
module cfg_word_serdes #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              mode_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              shift_i,
  input  logic              last_i,
  input  logic              bit_i,
  output logic              bit_o,
  output logic              empty_o,
  output logic              final_o,
  output logic              word_done_o,
  output logic [WORD_W-1:0] word_o
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] sh_q, sh_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              word_end;

  assign word_end    = (idx_q == IDX_LAST) || last_i;
  assign bit_o       = sh_q[0];
  assign empty_o     = !valid_q;
  assign final_o     = valid_q && (idx_q == IDX_LAST);
  assign word_done_o = mode_i && shift_i && word_end;
  // The register is kept zero above the index, so OR-ing in the new bit pads for free.
  assign word_o      = sh_q | (WORD_W'(bit_i) << idx_q);

  always_comb begin
    sh_d    = sh_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (clear_i) begin
      sh_d    = '0;
      idx_d   = '0;
      valid_d = 1'b0;
    end else if (!mode_i) begin
      if (shift_i) begin
        sh_d = sh_q >> 1;
        if (word_end) begin
          idx_d   = '0;
          valid_d = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      // A load during the final shift keeps the buffer full with no bubble.
      if (load_i) begin
        sh_d    = data_i;
        idx_d   = '0;
        valid_d = 1'b1;
      end
    end else if (shift_i) begin
      if (word_end) begin
        sh_d  = '0;
        idx_d = '0;
      end else begin
        sh_d  = word_o;
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Sequences a PE serial configuration chain: clear-and-load from words, or
// non-destructive recirculating readback into words.
module cfg_chain_loader
  import cfg_chain_loader_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_mode,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              config_reset,
  output logic              config_clk_en,
  output logic              config_in,
  input  logic              config_out
);

  localparam int CNT_W   = $clog2(CHAIN_LEN + 1);
  localparam int N_WORDS = words_per_chain(CHAIN_LEN, WORD_W);
  localparam int WCNT_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0]  ALL_BITS  = CNT_W'(CHAIN_LEN);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(N_WORDS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic                err_q, err_d;
  logic                rd_valid_q, rd_valid_d;
  logic [WORD_W-1:0]   rd_data_q, rd_data_d;

  logic                start_accept, at_last_bit, chain_done, rd_accept;
  logic                ser_clear, ser_mode, ser_load, ser_shift;
  logic                ser_bit, ser_empty, ser_final, ser_word_done;
  logic [WORD_W-1:0]   ser_word;

  assign start_accept = (state_q == ST_IDLE) && cfg_start;
  assign at_last_bit  = (bit_cnt_q == LAST_BIT);
  assign chain_done   = (bit_cnt_q == ALL_BITS);
  assign rd_accept    = rd_valid_q && rd_ready;

  assign err      = err_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  cfg_word_serdes #(
    .WORD_W (WORD_W)
  ) u_serdes (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (ser_clear),
    .mode_i      (ser_mode),
    .load_i      (ser_load),
    .data_i      (wr_data),
    .shift_i     (ser_shift),
    .last_i      (at_last_bit),
    .bit_i       (config_out),
    .bit_o       (ser_bit),
    .empty_o     (ser_empty),
    .final_o     (ser_final),
    .word_done_o (ser_word_done),
    .word_o      (ser_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cfg_start) state_d = (cfg_mode == MODE_LOAD) ? ST_CLR : ST_READ;
      ST_CLR:  state_d = ST_LOAD;
      ST_LOAD: if (ser_shift && at_last_bit) state_d = ST_FIN;
      ST_READ: if (rd_accept && (word_cnt_q == LAST_WORD)) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    config_reset  = 1'b0;
    config_clk_en = 1'b0;
    config_in     = 1'b0;
    wr_ready      = 1'b0;
    ser_clear     = start_accept;
    ser_mode      = (state_q == ST_READ);
    ser_load      = 1'b0;
    ser_shift     = 1'b0;
    case (state_q)
      ST_CLR: begin
        busy         = 1'b1;
        config_reset = 1'b1;
      end
      ST_LOAD: begin
        busy          = 1'b1;
        ser_shift     = !ser_empty;
        config_clk_en = ser_shift;
        config_in     = ser_shift && ser_bit;
        // No new word once the final chain bit is leaving; its leftovers are dropped.
        wr_ready      = (ser_empty || ser_final) && !(ser_shift && at_last_bit);
        ser_load      = wr_valid && wr_ready;
      end
      ST_READ: begin
        busy          = 1'b1;
        ser_shift     = !chain_done && (!rd_valid_q || rd_ready);
        config_clk_en = ser_shift;
        config_in     = ser_shift && config_out;
      end
      ST_FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    if (start_accept) begin
      bit_cnt_d  = '0;
      word_cnt_d = '0;
      err_d      = 1'b0;
      rd_valid_d = 1'b0;
    end else begin
      if (ser_shift) bit_cnt_d = bit_cnt_q + 1'b1;
      // A cleared chain must return zeros while the new bitstream pushes it out.
      if ((state_q == ST_LOAD) && ser_shift && config_out) err_d = 1'b1;
      if ((state_q == ST_READ) && rd_accept) word_cnt_d = word_cnt_q + 1'b1;
      if (ser_word_done) begin
        rd_valid_d = 1'b1;
        rd_data_d  = ser_word;
      end else if (rd_accept) begin
        rd_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Sequences the serial configuration chain of a PE block (the config_cell / switch chain) from a parallel word interface.
- Two modes:
  - Load: clears the chain, then shifts a bitstream in.
  - Readback: recirculates the chain non-destructively and returns its contents as words.
- Sits between the array-level configuration controller and each PE's config_in/config_out pins.
- Runs entirely on the datapath clock. The chain's shift edge is qualified by config_clk_en, which feeds an external clock-gating cell.

Parameters:
- WORD_W, 32, width of write/read data words.
- CHAIN_LEN, 64, total bits in the target chain (≥1).

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_start  in  1  single-cycle start; sampled only in IDLE.
- cfg_mode  in  1  sampled with cfg_start; 0 = load, 1 = readback.
- wr_data  in  WORD_W  load word; bits are shifted out LSB first.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  loader accepts wr_data this cycle.
- rd_data  out  WORD_W  readback word.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts rd_data.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at end of an operation.
- err  out  1  sticky integrity error; cleared by the next accepted cfg_start.
- config_reset  out  1  chain clear; drives the chain's config_reset.
- config_clk_en  out  1  chain shift enable; one chain shift per clk edge while high.
- config_in  out  1  serial bit into the chain.
- config_out  in  1  serial bit returned from the chain tail.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, word buffers empty. Reset is asynchronous and can occur mid-operation. After reset, chain contents are undefined and are not re-cleared until the next load.
- States: IDLE, CLR, LOAD, READ, FIN.
- IDLE:
  - cfg_start=1 with mode 0 → CLR, and err cleared.
  - cfg_start=1 with mode 1 → READ, and err cleared.
  - cfg_start while busy is ignored.
- CLR: config_reset=1 for exactly one cycle, config_clk_en=0 → LOAD.
- LOAD:
  - wr_ready=1 when the shift buffer is empty, or when it is shifting its final bit (zero-bubble back-to-back).
  - A word is accepted on wr_valid & wr_ready and starts shifting the next cycle.
  - Each cycle the buffer holds bits: config_clk_en=1, config_in = current bit, bit counter +1.
  - Simultaneously, config_out must be 0 (post-clear value). Any 1 sets err.
  - Empty buffer: config_clk_en=0 (stall, chain holds).
  - Once CHAIN_LEN bits have shifted → FIN. Remaining bits of the last word are discarded and wr_ready drops.
  - Words needed = ceil(CHAIN_LEN/WORD_W).
- READ:
  - Each enabled cycle: config_in = config_out (recirculate), and config_out is captured into the rd word at the current bit index (LSB first).
  - Shifting is enabled only while the rd register is not holding an unaccepted word. With rd_valid=1 and rd_ready=0, config_clk_en=0 and the chain holds.
  - A word completes on WORD_W bits, or on the final chain bit with upper bits zero-padded. rd_valid asserts the next cycle.
  - A completed word is held until rd_ready. A new word may be captured in the same cycle as acceptance.
  - After CHAIN_LEN shifts the chain is restored exactly. Go to FIN once the last word is accepted.
  - Readback bit order equals load bit order.
- FIN: done=1 for one cycle → IDLE.
- Counters:
  - bit counter: $clog2(CHAIN_LEN+1) bits, never wraps.
  - index within word: $clog2(WORD_W) bits, wraps at WORD_W-1 or at chain end.
- Latency, load with no stalls: cfg_start → config_reset at +1 → first shift no earlier than +3 → done 1 cycle after the last shift.
- config_reset is asserted only in CLR.

Decomposition:
- Package cfg_chain_loader_pkg:
  - state enum (IDLE, CLR, LOAD, READ, FIN).
  - MODE_LOAD/MODE_READ constants.
  - helper function for words-per-chain, ceil(CHAIN_LEN/WORD_W).
- One natural sub-module: cfg_word_serdes.
  - Contents: the WORD_W shift register plus bit index.
  - Direction: serialises in load mode, deserialises with zero-pad in readback mode.
  - Reused by the array-level controller.

Test Plan:
- CHAIN_LEN=13, WORD_W=8. Load 0xA5, 0x1F with no stalls → exactly 13 cycles of config_clk_en=1, config_in sequence 1,0,1,0,0,1,0,1,1,1,1,1,1. done pulses once and err=0.
- Same params. Load 0xA5, 0xFF, then readback → rd_data 0xA5 then 0x1F (upper 3 bits padded). Second readback returns identical words, proving the chain is restored.
- Load with wr_valid low for 4 cycles between words → config_clk_en=0 for those 4 cycles with no extra shifts. Final chain contents match the no-stall case.
- Readback with rd_ready held low 5 cycles after the first word → config_clk_en=0 and rd_data stable at 0xA5 throughout. Completion is unaffected.
- Force config_out=1 on the 3rd load shift → err=1 at done and held. Next cfg_start clears err to 0.
- Assert reset after 6 load shifts → same cycle: busy, config_clk_en, wr_ready, done all 0, state IDLE. A new load then completes normally.
